// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
//   - controller state encoding
//   - ALUOp request codes and ALU control codes driven to the ALU
//   - opcode and funct constants
//   - ALUSrcB / PCSrc select codes
// Optional feature macro MC_CTRL_BNE_EN (used in multicycle_control.sv) adds bne support.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExec,
    StAluWb,
    StBranch,
    StAddiEx,
    StAddiWb,
    StJump
  } state_e;

  // Operation requested from the ALU decoder by the main FSM.
  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  // ALU control codes.
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  // Opcodes.
  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type funct codes.
  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  // ALUSrcB selects.
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBOne   = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // PCSrc selects.
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp request plus the R-type funct field to the 3-bit ALU
// control code, and flags funct values that are not supported.
// Ports:
//   alu_op_i        ALUOp request (add / sub / from funct)
//   funct_i         instr[5:0]
//   alu_control_o   ALU control code; always one of the five legal codes
//   illegal_funct_o funct is not one of add/sub/and/or/slt (independent of alu_op_i)
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       illegal_funct_o
);

  logic [2:0] funct_ctl;

  // Kept separate from the ALUOp mux so the illegal flag depends on funct only; the FSM reads
  // it while choosing ALUOp.
  always_comb begin
    illegal_funct_o = 1'b0;
    funct_ctl       = AluAdd;
    case (funct_i)
      FunctAdd: funct_ctl = AluAdd;
      FunctSub: funct_ctl = AluSub;
      FunctAnd: funct_ctl = AluAnd;
      FunctOr:  funct_ctl = AluOr;
      FunctSlt: funct_ctl = AluSlt;
      default:  illegal_funct_o = 1'b1;
    endcase
  end

  always_comb begin
    alu_control_o = AluAdd;
    case (alu_op_i)
      AluOpAdd:   alu_control_o = AluAdd;
      AluOpSub:   alu_control_o = AluSub;
      AluOpFunct: alu_control_o = funct_ctl;
      default:    alu_control_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller. Sequences fetch/decode/execute/memory/writeback from
// Op/Funct, gates PC/IR/register-file/memory enables and drives the ALU control code.
// Memory states stall on MemReady. Optional macro MC_CTRL_BNE_EN adds bne (000101).
// Ports:
//   Clk, ResetN   rising-edge clock, asynchronous active-low reset
//   Op, Funct     instruction fields from IR (valid from DECODE onward)
//   Zero          ALU zero flag
//   MemReady      memory completes the current access this cycle
//   MemReq/MemWrite/IorD                    memory interface controls
//   IRWrite/PCEn/RegWrite                   state enables
//   RegDst/MemtoReg/ALUSrcA/ALUSrcB/PCSrc   datapath selects
//   ALUControl    ALU operation code
//   IllegalOp     one-cycle pulse in DECODE on unsupported Op/Funct
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic [OP_W-1:0]    Op,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               MemReq,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               IllegalOp
);

  state_e  state_q, state_d;
  alu_op_e alu_op;
  logic    illegal_funct;
  logic    branch_taken;

  multicycle_control_alu_decoder u_alu_decoder (
    .alu_op_i        (alu_op),
    .funct_i         (Funct),
    .alu_control_o   (ALUControl),
    .illegal_funct_o (illegal_funct)
  );

`ifdef MC_CTRL_BNE_EN
  assign branch_taken = (Op == OpBne) ? ~Zero : Zero;
`else
  assign branch_taken = Zero;
`endif

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    alu_op    = AluOpAdd;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SrcBReg;
    PCSrc     = PcSrcAlu;
    PCEn      = 1'b0;
    IllegalOp = 1'b0;

    case (state_q)
      StFetch: begin
        MemReq  = 1'b1;
        ALUSrcB = SrcBOne;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCEn    = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // ALU precomputes the branch target while the opcode is decoded.
        ALUSrcB = SrcBImmSh;
        case (Op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType: begin
            if (illegal_funct) begin
              IllegalOp = 1'b1;
              state_d   = StFetch;
            end else begin
              state_d = StExec;
            end
          end
          OpBeq:  state_d = StBranch;
`ifdef MC_CTRL_BNE_EN
          OpBne:  state_d = StBranch;
`endif
          OpAddi: state_d = StAddiEx;
          OpJ:    state_d = StJump;
          default: begin
            IllegalOp = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        state_d = (Op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (MemReady) state_d = StMemWb;
      end
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_d = StFetch;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA = 1'b1;
        alu_op  = AluOpSub;
        PCSrc   = PcSrcAluOut;
        PCEn    = branch_taken;
        state_d = StFetch;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StJump: begin
        PCSrc   = PcSrcJump;
        PCEn    = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Asserting reset kills every output immediately, not just at the next edge.
    if (!ResetN) begin
      alu_op    = AluOpAdd;
      MemReq    = 1'b0;
      MemWrite  = 1'b0;
      IorD      = 1'b0;
      IRWrite   = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      RegWrite  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SrcBReg;
      PCSrc     = PcSrcAlu;
      PCEn      = 1'b0;
      IllegalOp = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each test pushes per-cycle stimulus plus the
// expected outputs onto a scoreboard queue, then drains it one clock at a time, comparing the
// DUT outputs (under a care mask) a little after each falling edge.
module tb_multicycle_control;

  logic       Clk = 1'b0;
  logic       ResetN = 1'b0;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;
  logic       MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic       IllegalOp;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;

  multicycle_control dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .Op         (Op),
    .Funct      (Funct),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .MemReq     (MemReq),
    .MemWrite   (MemWrite),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .PCSrc      (PCSrc),
    .PCEn       (PCEn),
    .IllegalOp  (IllegalOp)
  );

  always #5 Clk = ~Clk;

  // Bit order: MemReq MemWrite IorD IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB[1:0]
  //            ALUControl[2:0] PCSrc[1:0] PCEn IllegalOp
  logic [16:0] obs;
  assign obs = {MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
                ALUControl, PCSrc, PCEn, IllegalOp};

  localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AND_ = 3'b000, OR_ = 3'b001, SLT = 3'b111;
  localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] OP5 = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;

  // Enables are always checked (they must be 0 wherever not asserted); selects only where defined.
  localparam logic [16:0] EN     = 17'b1_1_0_1_0_0_1_0_00_000_00_1_1;
  localparam logic [16:0] C_IORD = 17'd1 << 14;
  localparam logic [16:0] C_RD   = 17'd1 << 12;
  localparam logic [16:0] C_M2R  = 17'd1 << 11;
  localparam logic [16:0] C_SA   = 17'd1 << 9;
  localparam logic [16:0] C_SB   = 17'd3 << 7;
  localparam logic [16:0] C_AC   = 17'd7 << 4;
  localparam logic [16:0] C_PS   = 17'd3 << 2;

  typedef struct packed {
    logic [16:0] val;
    logic [16:0] mask;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       mr;
    logic       zero;
    logic [5:0] op;
    logic [5:0] funct;
    exp_t       e;
    string      name;
  } step_t;

  step_t sb[$];
  int    n_checks = 0;
  int    n_fail = 0;

  function automatic logic [16:0] pk(input logic mrq, mw, iord, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sbs, input logic [2:0] ac,
                                     input logic [1:0] ps, input logic pe, il);
    return {mrq, mw, iord, irw, rd, m2r, rw, sa, sbs, ac, ps, pe, il};
  endfunction

  function automatic exp_t mk(input logic [16:0] v, input logic [16:0] care);
    exp_t e;
    e.val  = v;
    e.mask = care | EN;
    return e;
  endfunction

  function automatic exp_t e_reset();
    exp_t e;
    e.val  = pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 2'b00, 0, 0);
    e.mask = '1;
    return e;
  endfunction
  function automatic exp_t e_fetch(input logic mr);
    return mk(pk(1, 0, 0, mr, 0, 0, 0, 0, 2'b01, ADD, 2'b00, mr, 0),
              C_IORD | C_SA | C_SB | C_AC | C_PS);
  endfunction
  function automatic exp_t e_decode(input logic il);
    return mk(pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 2'b00, 0, il), C_SA | C_SB | C_AC);
  endfunction
  function automatic exp_t e_memadr();
    return mk(pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ADD, 2'b00, 0, 0), C_SA | C_SB | C_AC);
  endfunction
  function automatic exp_t e_memrd();
    return mk(pk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, ADD, 2'b00, 0, 0), C_IORD);
  endfunction
  function automatic exp_t e_memwb();
    return mk(pk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, ADD, 2'b00, 0, 0), C_RD | C_M2R);
  endfunction
  function automatic exp_t e_memwr();
    return mk(pk(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, ADD, 2'b00, 0, 0), C_IORD);
  endfunction
  function automatic exp_t e_exec(input logic [2:0] ac);
    return mk(pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, ac, 2'b00, 0, 0), C_SA | C_SB | C_AC);
  endfunction
  function automatic exp_t e_aluwb();
    return mk(pk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, ADD, 2'b00, 0, 0), C_RD | C_M2R);
  endfunction
  function automatic exp_t e_branch(input logic pe);
    return mk(pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, SUB, 2'b01, pe, 0),
              C_SA | C_SB | C_AC | C_PS);
  endfunction
  function automatic exp_t e_addiex();
    return mk(pk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ADD, 2'b00, 0, 0), C_SA | C_SB | C_AC);
  endfunction
  function automatic exp_t e_addiwb();
    return mk(pk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, ADD, 2'b00, 0, 0), C_RD | C_M2R);
  endfunction
  function automatic exp_t e_jump();
    return mk(pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 2'b10, 1, 0), C_PS);
  endfunction

  task automatic push(input logic rst, mr, zero, input logic [5:0] op, funct, input exp_t e,
                      input string name);
    step_t s;
    s.rst = rst; s.mr = mr; s.zero = zero; s.op = op; s.funct = funct; s.e = e; s.name = name;
    sb.push_back(s);
  endtask

  // Pops the next step, drives it after the falling edge and lets outputs settle.
  task automatic next_step(output step_t s);
    s = sb.pop_front();
    @(negedge Clk);
    ResetN = s.rst; MemReady = s.mr; Zero = s.zero; Op = s.op; Funct = s.funct;
    #1;
  endtask

  task automatic test_reset();
    step_t s;
    for (int i = 0; i < 3; i++) push(0, 1, 1, RTYPE, 6'b100000, e_reset(), "reset_hold");
    push(1, 0, 0, JMP, 6'd0, e_fetch(0), "reset_fetch_wait");
    push(1, 1, 0, JMP, 6'd0, e_fetch(1), "reset_fetch_latch");
    push(1, 1, 0, JMP, 6'd0, e_decode(0), "j_decode");
    push(1, 1, 0, JMP, 6'd0, e_jump(), "j_jump");
    push(1, 0, 0, JMP, 6'd0, e_fetch(0), "j_back_to_fetch");
    while (sb.size() != 0) begin
      next_step(s);
      n_checks++;
      if ((obs & s.e.mask) !== (s.e.val & s.e.mask)) begin
        n_fail++;
        $display("FAIL reset/%s: got %b, expected %b (mask %b)", s.name, obs, s.e.val,
                 s.e.mask);
      end
    end
  endtask

  task automatic test_rtype();
    step_t s;
    logic [5:0] fn[5];
    logic [2:0] ac[5];
    fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ac = '{ADD, SUB, AND_, OR_, SLT};
    for (int i = 0; i < 5; i++) begin
      push(1, 1, 0, RTYPE, fn[i], e_fetch(1), "r_fetch");
      push(1, 1, 0, RTYPE, fn[i], e_decode(0), "r_decode");
      push(1, 1, 0, RTYPE, fn[i], e_exec(ac[i]), "r_exec");
      push(1, 1, 0, RTYPE, fn[i], e_aluwb(), "r_aluwb");
    end
    push(1, 0, 0, RTYPE, 6'd0, e_fetch(0), "r_back_to_fetch");
    while (sb.size() != 0) begin
      next_step(s);
      n_checks++;
      if ((obs & s.e.mask) !== (s.e.val & s.e.mask)) begin
        n_fail++;
        $display("FAIL rtype/%s: got %b, expected %b (mask %b)", s.name, obs, s.e.val,
                 s.e.mask);
      end
    end
  endtask

  task automatic test_illegal();
    step_t s;
    push(1, 1, 0, RTYPE, 6'b000001, e_fetch(1), "badfunct_fetch");
    push(1, 1, 0, RTYPE, 6'b000001, e_decode(1), "badfunct_decode");
    push(1, 1, 0, 6'b111111, 6'd0, e_fetch(1), "badop_fetch");
    push(1, 1, 0, 6'b111111, 6'd0, e_decode(1), "badop_decode");
    push(1, 0, 0, 6'b111111, 6'd0, e_fetch(0), "badop_back_to_fetch");
    while (sb.size() != 0) begin
      next_step(s);
      n_checks++;
      if ((obs & s.e.mask) !== (s.e.val & s.e.mask)) begin
        n_fail++;
        $display("FAIL illegal/%s: got %b, expected %b (mask %b)", s.name, obs, s.e.val,
                 s.e.mask);
      end
    end
  endtask

  task automatic test_mem();
    step_t s;
    // lw, two wait cycles in MEMRD: 7 cycles.
    push(1, 1, 0, LW, 6'd0, e_fetch(1), "lw_fetch");
    push(1, 1, 0, LW, 6'd0, e_decode(0), "lw_decode");
    push(1, 1, 0, LW, 6'd0, e_memadr(), "lw_memadr");
    push(1, 0, 0, LW, 6'd0, e_memrd(), "lw_memrd_wait1");
    push(1, 0, 0, LW, 6'd0, e_memrd(), "lw_memrd_wait2");
    push(1, 1, 0, LW, 6'd0, e_memrd(), "lw_memrd_done");
    push(1, 1, 0, LW, 6'd0, e_memwb(), "lw_memwb");
    // sw, no wait: 4 cycles.
    push(1, 1, 0, SW, 6'd0, e_fetch(1), "sw_fetch");
    push(1, 1, 0, SW, 6'd0, e_decode(0), "sw_decode");
    push(1, 1, 0, SW, 6'd0, e_memadr(), "sw_memadr");
    push(1, 1, 0, SW, 6'd0, e_memwr(), "sw_memwr");
    push(1, 0, 0, SW, 6'd0, e_fetch(0), "sw_back_to_fetch");
    while (sb.size() != 0) begin
      next_step(s);
      n_checks++;
      if ((obs & s.e.mask) !== (s.e.val & s.e.mask)) begin
        n_fail++;
        $display("FAIL mem/%s: got %b, expected %b (mask %b)", s.name, obs, s.e.val, s.e.mask);
      end
    end
  endtask

  task automatic test_branch();
    step_t s;
    push(1, 1, 1, BEQ, 6'd0, e_fetch(1), "beq_t_fetch");
    push(1, 1, 1, BEQ, 6'd0, e_decode(0), "beq_t_decode");
    push(1, 1, 1, BEQ, 6'd0, e_branch(1), "beq_taken");
    push(1, 1, 0, BEQ, 6'd0, e_fetch(1), "beq_n_fetch");
    push(1, 1, 0, BEQ, 6'd0, e_decode(0), "beq_n_decode");
    push(1, 1, 0, BEQ, 6'd0, e_branch(0), "beq_not_taken");
`ifdef MC_CTRL_BNE_EN
    push(1, 1, 0, OP5, 6'd0, e_fetch(1), "bne_t_fetch");
    push(1, 1, 0, OP5, 6'd0, e_decode(0), "bne_t_decode");
    push(1, 1, 0, OP5, 6'd0, e_branch(1), "bne_taken");
    push(1, 1, 1, OP5, 6'd0, e_fetch(1), "bne_n_fetch");
    push(1, 1, 1, OP5, 6'd0, e_decode(0), "bne_n_decode");
    push(1, 1, 1, OP5, 6'd0, e_branch(0), "bne_not_taken");
`else
    push(1, 1, 0, OP5, 6'd0, e_fetch(1), "op5_fetch");
    push(1, 1, 0, OP5, 6'd0, e_decode(1), "op5_illegal");
`endif
    push(1, 0, 0, OP5, 6'd0, e_fetch(0), "branch_back_to_fetch");
    while (sb.size() != 0) begin
      next_step(s);
      n_checks++;
      if ((obs & s.e.mask) !== (s.e.val & s.e.mask)) begin
        n_fail++;
        $display("FAIL branch/%s: got %b, expected %b (mask %b)", s.name, obs, s.e.val,
                 s.e.mask);
      end
    end
  endtask

  // MemReady low outside memory states must not stall.
  task automatic test_addi_ignore_ready();
    step_t s;
    push(1, 1, 0, ADDI, 6'd0, e_fetch(1), "addi_fetch");
    push(1, 0, 0, ADDI, 6'd0, e_decode(0), "addi_decode");
    push(1, 0, 0, ADDI, 6'd0, e_addiex(), "addi_ex");
    push(1, 0, 0, ADDI, 6'd0, e_addiwb(), "addi_wb");
    push(1, 0, 0, ADDI, 6'd0, e_fetch(0), "addi_back_to_fetch");
    while (sb.size() != 0) begin
      next_step(s);
      n_checks++;
      if ((obs & s.e.mask) !== (s.e.val & s.e.mask)) begin
        n_fail++;
        $display("FAIL addi/%s: got %b, expected %b (mask %b)", s.name, obs, s.e.val,
                 s.e.mask);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t s;
    exp_t  r;
    push(1, 1, 0, SW, 6'd0, e_fetch(1), "abort_fetch");
    push(1, 1, 0, SW, 6'd0, e_decode(0), "abort_decode");
    push(1, 1, 0, SW, 6'd0, e_memadr(), "abort_memadr");
    push(1, 0, 0, SW, 6'd0, e_memwr(), "abort_memwr_wait");
    while (sb.size() != 0) begin
      next_step(s);
      n_checks++;
      if ((obs & s.e.mask) !== (s.e.val & s.e.mask)) begin
        n_fail++;
        $display("FAIL async/%s: got %b, expected %b (mask %b)", s.name, obs, s.e.val,
                 s.e.mask);
      end
    end
    // Drop reset between clock edges; outputs must clear without waiting for a clock.
    #1 ResetN = 1'b0;
    #1;
    r = e_reset();
    n_checks++;
    if (obs !== r.val) begin
      n_fail++;
      $display("FAIL async/clear_same_cycle: got %b, expected %b", obs, r.val);
    end
    push(0, 0, 0, SW, 6'd0, e_reset(), "abort_reset_hold");
    push(1, 0, 0, RTYPE, 6'b100000, e_fetch(0), "restart_fetch_wait");
    push(1, 1, 0, RTYPE, 6'b100000, e_fetch(1), "restart_fetch");
    push(1, 1, 0, RTYPE, 6'b100000, e_decode(0), "restart_decode");
    push(1, 1, 0, RTYPE, 6'b100000, e_exec(ADD), "restart_exec");
    push(1, 1, 0, RTYPE, 6'b100000, e_aluwb(), "restart_aluwb");
    push(1, 0, 0, RTYPE, 6'b100000, e_fetch(0), "restart_back_to_fetch");
    while (sb.size() != 0) begin
      next_step(s);
      n_checks++;
      if ((obs & s.e.mask) !== (s.e.val & s.e.mask)) begin
        n_fail++;
        $display("FAIL async/%s: got %b, expected %b (mask %b)", s.name, obs, s.e.val,
                 s.e.mask);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_illegal();
    test_mem();
    test_branch();
    test_addi_ignore_ready();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
